// File: rtl/signed_mult8_seq_if.sv
// rtl/signed_mult8_seq_if.sv - request/result bundle for the sequential signed multiplier
interface signed_mult8_seq_if;
    logic        start;
    logic [7:0]  multiplicand_a;
    logic [7:0]  multiplier_b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start, multiplicand_a, multiplier_b,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand_a, multiplier_b,
        output product, busy, done
    );
endinterface

// File: rtl/signed_mult8_seq.sv
// rtl/signed_mult8_seq.sv - 8x8 signed radix-2 Booth multiplier, one step per clock
module signed_mult8_seq (
    input  logic              clk,
    input  logic              rst,
    signed_mult8_seq_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        last_step;

    logic [8:0]  a_q;
    logic [7:0]  q_q;
    logic        qm1_q;
    logic [7:0]  m_q;
    logic [2:0]  count_q;
    logic [15:0] product_q;
    logic        done_q;

    logic [8:0]  m_ext;
    logic [8:0]  sum;
    logic [8:0]  a_next;
    logic [7:0]  q_next;
    logic        qm1_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept only when idle; the eighth step returns to idle
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (count_q == 3'd7) begin
                    last_step = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One Booth recoding step followed by an arithmetic right shift of {A,Q,q_-1}
    always_comb begin
        m_ext = {m_q[7], m_q};
        sum   = a_q;
        case ({q_q[0], qm1_q})
            2'b10:   sum = a_q - m_ext;
            2'b01:   sum = a_q + m_ext;
            default: sum = a_q;
        endcase
        a_next   = {sum[8], sum[8:1]};
        q_next   = {sum[0], q_q[7:1]};
        qm1_next = q_q[0];
    end

    // Datapath: load on accept, step while running, publish the product on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= 9'd0;
            q_q       <= 8'd0;
            qm1_q     <= 1'b0;
            m_q       <= 8'd0;
            count_q   <= 3'd0;
            product_q <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= 9'd0;
                q_q     <= bus.multiplier_b;
                qm1_q   <= 1'b0;
                m_q     <= bus.multiplicand_a;
                count_q <= 3'd0;
            end else if (state_q == S_RUN) begin
                a_q     <= a_next;
                q_q     <= q_next;
                qm1_q   <= qm1_next;
                count_q <= count_q + 3'd1;
                if (last_step) begin
                    product_q <= {a_next[7:0], q_next};
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_signed_mult8_seq.sv
// tb/tb_signed_mult8_seq.sv - self-checking bench for signed_mult8_seq
module tb_signed_mult8_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    signed_mult8_seq_if bus ();

    signed_mult8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
        int ai;
        int bi;
        ai = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        bi = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        return 16'(ai * bi);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from an idle cycle, scramble operands after accept,
    // then wait for done and check latency and product.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int cycles;
        logic [15:0] exp;
        exp = ref_mult(a, b);
        bus.start          = 1'b1;
        bus.multiplicand_a = a;
        bus.multiplier_b   = b;
        tick();
        bus.start          = 1'b0;
        bus.multiplicand_a = 8'($urandom);
        bus.multiplier_b   = 8'($urandom);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 16'(cycles), 16'd8);
        check({tag, "_product"}, bus.product, exp);
    endtask

    initial begin
        int cycles;
        int done_at[$];
        logic seen_done;
        logic [7:0] ra;
        logic [7:0] rb;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand_a = 8'h00;
        bus.multiplier_b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("reset_product", bus.product, 16'h0000);
        check("reset_busy", 16'(bus.busy), 16'd0);
        check("reset_done", 16'(bus.done), 16'd0);

        // Powers of two
        do_op(8'h01, 8'h01, "p01");
        do_op(8'h02, 8'h02, "p02");
        do_op(8'h10, 8'h10, "p10");
        do_op(8'h20, 8'h20, "p20");
        do_op(8'h40, 8'h40, "p40");
        // Negative squares
        do_op(8'hFF, 8'hFF, "nFF");
        do_op(8'hFE, 8'hFE, "nFE");
        do_op(8'hF0, 8'hF0, "nF0");
        do_op(8'hC0, 8'hC0, "nC0");
        do_op(8'h80, 8'h80, "n80");
        check("max_product_const", bus.product, 16'h4000);
        // Mixed signs
        do_op(8'h01, 8'h80, "m01x80");
        do_op(8'h7F, 8'h80, "m7Fx80");
        check("min_product_const", bus.product, 16'hC080);
        do_op(8'hFF, 8'h7F, "mFFx7F");
        do_op(8'h00, 8'h80, "m00x80");

        // Reset during step 4 discards the operation
        do_op(8'h7F, 8'h7F, "pre_reset");
        tick();
        bus.start = 1'b1;
        bus.multiplicand_a = 8'h35;
        bus.multiplier_b = 8'h27;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 16'(bus.busy), 16'd0);
        check("midrst_done", 16'(bus.done), 16'd0);
        check("midrst_product", bus.product, 16'h0000);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("midrst_no_done", 16'(seen_done), 16'd0);
        check("midrst_product_hold", bus.product, 16'h0000);

        // start held high: one result every 9 cycles
        bus.start = 1'b1;
        bus.multiplicand_a = 8'h03;
        bus.multiplier_b = 8'hFB;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) check("held_busy_after_accept", 16'(bus.busy), 16'd1);
            if (bus.done === 1'b1) begin
                done_at.push_back(i - 1);
                check("held_product", bus.product, 16'hFFF1);
            end
        end
        bus.start = 1'b0;
        check("held_count", 16'(done_at.size()), 16'd4);
        for (int k = 0; k < done_at.size() && k < 4; k++)
            check("held_spacing", 16'(done_at[k]), 16'(8 + 9 * k));
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check("held_drain", 16'(bus.done), 16'd1);

        // Second start while busy is ignored
        tick();
        bus.start = 1'b1;
        bus.multiplicand_a = 8'h05;
        bus.multiplier_b = 8'h06;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.multiplicand_a = 8'h07;
        bus.multiplier_b = 8'h09;
        tick();
        bus.start = 1'b0;
        check("ignore_product_stable", bus.product, ref_mult(8'h03, 8'hFB));
        cycles = 3;
        while (bus.done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check("ignore_latency", 16'(cycles), 16'd8);
        check("ignore_product", bus.product, 16'h001E);
        tick();
        check("ignore_no_second_busy", 16'(bus.busy), 16'd0);
        check("done_one_cycle", 16'(bus.done), 16'd0);

        // Random operands back-to-back against the arithmetic reference
        for (int n = 0; n < 4000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
